// File: rtl/nand_bist_checker.sv
// nand_bist_checker
//   Built-in self-test sweeper for a combinational N_IN-input NAND.
//   Drives every input vector 0 .. 2^N_IN-1 onto `pattern`, holds each one for
//   SETTLE_CYCLES cycles and then samples `f_in` for one cycle. The sample is
//   compared against ~&pattern. A sweep takes 2^N_IN*(SETTLE_CYCLES+1) cycles
//   from the accepted start edge to the DONE entry edge.
//
// Parameters
//   N_IN          DUT input count, which is also the pattern width
//   SETTLE_CYCLES cycles a vector is held before it is sampled (minimum 1)
//   ERR_W         error counter width; the counter saturates at all-ones
//
// Ports
//   clk           rising-edge system clock
//   rst_n         asynchronous active-low reset
//   start         one-cycle sweep request, honoured only in IDLE or DONE
//   pattern       vector driven to the DUT inputs (MSB = input a)
//   f_in          DUT output
//   busy          high while a sweep is in progress
//   done          one-cycle pulse when a sweep completes
//   pass          valid after done; high iff err_count == 0
//   err_count     saturating mismatch count for the last sweep
//   fail_valid    at least one mismatch has been captured
//   fail_pattern  first mismatching vector
//   sig           (NAND_BIST_SIGNATURE_EN only) 8-bit MISR over the sampled
//                 f_in values, polynomial x^8+x^4+x^3+x^2+1
//
// Optional feature macro: NAND_BIST_SIGNATURE_EN

module nand_bist_checker #(
    parameter int N_IN          = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [N_IN-1:0]   pattern,
    input  logic              f_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic              fail_valid,
    output logic [N_IN-1:0]   fail_pattern
`ifdef NAND_BIST_SIGNATURE_EN
    ,
    output logic [7:0]        sig
`endif
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t              state_q,        state_d;
    logic [N_IN-1:0]     pattern_q,      pattern_d;
    logic [CNT_W-1:0]    settle_q,       settle_d;
    logic                busy_q,         busy_d;
    logic                done_q,         done_d;
    logic                pass_q,         pass_d;
    logic [ERR_W-1:0]    err_q,          err_d;
    logic                fail_valid_q,   fail_valid_d;
    logic [N_IN-1:0]     fail_pattern_q, fail_pattern_d;
`ifdef NAND_BIST_SIGNATURE_EN
    logic [7:0]          sig_q,          sig_d;
`endif

    logic expected;
    logic mismatch;

    // Case inequality so that an X or Z from the DUT counts as a mismatch.
    assign expected = ~&pattern_q;
    assign mismatch = (f_in !== expected);

    always_comb begin
        state_d        = state_q;
        pattern_d      = pattern_q;
        settle_d       = settle_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        pass_d         = pass_q;
        err_d          = err_q;
        fail_valid_d   = fail_valid_q;
        fail_pattern_d = fail_pattern_q;
`ifdef NAND_BIST_SIGNATURE_EN
        sig_d          = sig_q;
`endif

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d        = S_SETTLE;
                    pattern_d      = '0;
                    settle_d       = SETTLE_LOAD;
                    busy_d         = 1'b1;
                    pass_d         = 1'b0;
                    err_d          = '0;
                    fail_valid_d   = 1'b0;
                    fail_pattern_d = '0;
`ifdef NAND_BIST_SIGNATURE_EN
                    sig_d          = '0;
`endif
                end
            end

            S_SETTLE: begin
                if (settle_q == '0) begin
                    state_d = S_SAMPLE;
                end else begin
                    settle_d = settle_q - CNT_W'(1);
                end
            end

            S_SAMPLE: begin
                if (mismatch) begin
                    if (err_q != '1) begin
                        err_d = err_q + ERR_W'(1);
                    end
                    if (!fail_valid_q) begin
                        fail_valid_d   = 1'b1;
                        fail_pattern_d = pattern_q;
                    end
                end
`ifdef NAND_BIST_SIGNATURE_EN
                sig_d = {sig_q[6:0], 1'b0} ^ (sig_q[7] ? 8'h1D : 8'h00) ^ {7'b0, f_in};
`endif
                // Termination is decided on the all-ones vector, so the
                // pattern never wraps back to zero.
                if (pattern_q == '1) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    // err_d already includes this final sample.
                    pass_d  = (err_d == '0);
                end else begin
                    state_d   = S_SETTLE;
                    pattern_d = pattern_q + N_IN'(1);
                    settle_d  = SETTLE_LOAD;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            pattern_q      <= '0;
            settle_q       <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            err_q          <= '0;
            fail_valid_q   <= 1'b0;
            fail_pattern_q <= '0;
`ifdef NAND_BIST_SIGNATURE_EN
            sig_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            pattern_q      <= pattern_d;
            settle_q       <= settle_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            pass_q         <= pass_d;
            err_q          <= err_d;
            fail_valid_q   <= fail_valid_d;
            fail_pattern_q <= fail_pattern_d;
`ifdef NAND_BIST_SIGNATURE_EN
            sig_q          <= sig_d;
`endif
        end
    end

    assign pattern      = pattern_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign err_count    = err_q;
    assign fail_valid   = fail_valid_q;
    assign fail_pattern = fail_pattern_q;
`ifdef NAND_BIST_SIGNATURE_EN
    assign sig          = sig_q;
`endif

endmodule

// File: tb/tb_nand_bist_checker.sv
// tb_nand_bist_checker
//   Drives nand_bist_checker (N_IN=4, SETTLE_CYCLES=2, ERR_W=5) with a
//   modelled NAND DUT whose behaviour is chosen by `mode`, plus a second
//   ERR_W=3 instance whose DUT output is stuck at 0 to exercise saturation.
//   Optional signature output is checked when NAND_BIST_SIGNATURE_EN is set.

module tb_nand_bist_checker;

    localparam int SWEEP = 48;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       f_in;
    logic [3:0] pattern;
    logic       busy, done, pass, fail_valid;
    logic [4:0] err_count;
    logic [3:0] fail_pattern;

    logic [3:0] pattern2;
    logic       busy2, done2, pass2, fail_valid2;
    logic [2:0] err_count2;
    logic [3:0] fail_pattern2;
`ifdef NAND_BIST_SIGNATURE_EN
    logic [7:0] sig, sig2;
`endif

    int          mode;   // 0 good, 1 stuck-1, 2 stuck-0, 3 vector 5 inverted, 4 random flips
    logic [15:0] mask;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    nand_bist_checker #(.N_IN(4), .SETTLE_CYCLES(2), .ERR_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern), .f_in(f_in),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_valid(fail_valid), .fail_pattern(fail_pattern)
`ifdef NAND_BIST_SIGNATURE_EN
        , .sig(sig)
`endif
    );

    nand_bist_checker #(.N_IN(4), .SETTLE_CYCLES(2), .ERR_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern2), .f_in(1'b0),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2),
        .fail_valid(fail_valid2), .fail_pattern(fail_pattern2)
`ifdef NAND_BIST_SIGNATURE_EN
        , .sig(sig2)
`endif
    );

    // Stand-in for the device under BIST.
    function automatic logic dut_f(input int m, input logic [15:0] msk, input logic [3:0] v);
        case (m)
            1:       return 1'b1;
            2:       return 1'b0;
            3:       return (v == 4'd5) ? 1'b0 : ~&v;
            4:       return (~&v) ^ msk[v];
            default: return ~&v;
        endcase
    endfunction

    always_comb f_in = dut_f(mode, mask, pattern);

    // Reference: result of a full sweep, from the checker's rules.
    function automatic void model(input int m, input logic [15:0] msk,
                                  output int e, output logic [3:0] fp,
                                  output bit fv, output bit ps, output logic [7:0] s);
        logic fv_l;
        e = 0; fp = 4'd0; fv_l = 1'b0; s = 8'h00;
        for (int v = 0; v < 16; v++) begin
            logic f;
            f = dut_f(m, msk, 4'(v));
            if (f != ((v == 15) ? 1'b0 : 1'b1)) begin
                if (e < 31) e = e + 1;
                if (!fv_l) begin fv_l = 1'b1; fp = 4'(v); end
            end
            s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00) ^ {7'b0, f};
        end
        fv = fv_l;
        ps = (e == 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Caller is at a negedge. Pulses start, then tracks the sweep cycle by
    // cycle; t counts edges after the start edge.
    task automatic run_sweep(input bit extra, input bit late, output int lat, output bit walk_ok);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        walk_ok = 1'b1;
        for (int t = 0; t < 200; t++) begin
            if (t < SWEEP) begin
                if (pattern !== 4'(t / 3) || busy !== 1'b1 || done !== 1'b0) walk_ok = 1'b0;
            end
            if (done === 1'b1) begin
                lat = t;
                if (busy !== 1'b0 || pattern !== 4'hF) walk_ok = 1'b0;
                break;
            end
            start = (extra && (t == 5 || t == 30)) || (late && t == SWEEP - 1);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    typedef struct {
        int         m;
        int         err;
        logic [3:0] fp;
        bit         fv;
        bit         ps;
    } vec_t;

    initial begin
        vec_t        tbl[4];
        int          lat, e;
        bit          walk, fv, ps;
        logic [3:0]  fp;
        logic [7:0]  s, s_good;
        logic [15:0] m_init;

        tbl[0] = '{0, 0,  4'h0, 1'b0, 1'b1};
        tbl[1] = '{1, 1,  4'hF, 1'b1, 1'b0};
        tbl[2] = '{2, 15, 4'h0, 1'b1, 1'b0};
        tbl[3] = '{3, 1,  4'h5, 1'b1, 1'b0};

        rst_n = 1'b0; start = 1'b0; mode = 0; mask = 16'h0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {busy, done, pass, err_count, fail_valid, fail_pattern, pattern}, 0);
`ifdef NAND_BIST_SIGNATURE_EN
        chk("reset_sig", sig, 8'h00);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        model(0, 16'h0, e, fp, fv, ps, s_good);
        for (int i = 0; i < 4; i++) begin
            mode = tbl[i].m;
            run_sweep(1'b0, 1'b0, lat, walk);
            chk($sformatf("latency_m%0d", i), lat, SWEEP);
            chk($sformatf("walk_m%0d", i), walk, 1);
            chk($sformatf("err_m%0d", i), err_count, tbl[i].err);
            chk($sformatf("fail_pat_m%0d", i), fail_pattern, tbl[i].fp);
            chk($sformatf("fail_valid_m%0d", i), fail_valid, tbl[i].fv);
            chk($sformatf("pass_m%0d", i), pass, tbl[i].ps);
`ifdef NAND_BIST_SIGNATURE_EN
            model(tbl[i].m, 16'h0, e, fp, fv, ps, s);
            chk($sformatf("sig_m%0d", i), sig, s);
            if (i == 3) chk("sig_differs_from_good", (sig != s_good), 1);
`endif
            chk($sformatf("sat_err_m%0d", i), err_count2, 3'd7);
            chk($sformatf("sat_fail_pat_m%0d", i), {fail_valid2, fail_pattern2, pass2}, {1'b1, 4'h0, 1'b0});
            @(negedge clk);
            chk($sformatf("done_width_m%0d", i), {done, busy}, 2'b00);
            chk($sformatf("hold_m%0d", i), {err_count, pass, fail_valid}, {5'(tbl[i].err), tbl[i].ps, tbl[i].fv});
        end

        for (int r = 0; r < 6; r++) begin
            m_init = 16'($urandom);
            if (r == 0) m_init = 16'h0000;
            mode = 4; mask = m_init;
            model(4, mask, e, fp, fv, ps, s);
            run_sweep(1'b0, 1'b0, lat, walk);
            chk($sformatf("rnd%0d_latency", r), lat, SWEEP);
            chk($sformatf("rnd%0d_err", r), err_count, e);
            chk($sformatf("rnd%0d_fail", r), {fail_valid, fail_pattern}, {fv, fp});
            chk($sformatf("rnd%0d_pass", r), pass, ps);
`ifdef NAND_BIST_SIGNATURE_EN
            chk($sformatf("rnd%0d_sig", r), sig, s);
`endif
            @(negedge clk);
        end

        // Starts while busy are ignored.
        mode = 0;
        run_sweep(1'b1, 1'b0, lat, walk);
        chk("busy_start_latency", lat, SWEEP);
        chk("busy_start_walk", walk, 1);
        chk("busy_start_pass", {pass, err_count}, {1'b1, 5'd0});
        @(negedge clk);

        // Start on the DONE entry edge is ignored; the next cycle is accepted.
        mode = 2;
        run_sweep(1'b0, 1'b1, lat, walk);
        chk("late_start_latency", lat, SWEEP);
        chk("late_start_err", err_count, 15);
        mode = 0;
        run_sweep(1'b0, 1'b0, lat, walk);
        chk("back_to_back_latency", lat, SWEEP);
        chk("back_to_back_walk", walk, 1);
        chk("back_to_back_cleared", {pass, err_count, fail_valid, fail_pattern}, {1'b1, 5'd0, 1'b0, 4'h0});
        @(negedge clk);

        // Reset mid-sweep aborts without a done pulse.
        mode = 2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", {busy, done, pass, err_count, fail_valid, fail_pattern, pattern}, 0);
`ifdef NAND_BIST_SIGNATURE_EN
        chk("abort_sig", sig, 8'h00);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        for (int t = 0; t < 60; t++) begin
            if (done === 1'b1 || busy === 1'b1) lat = 1;
            @(negedge clk);
        end
        chk("abort_no_done", lat, 0);
        mode = 0;
        run_sweep(1'b0, 1'b0, lat, walk);
        chk("after_abort_latency", lat, SWEEP);
        chk("after_abort_pass", {pass, err_count, fail_valid}, {1'b1, 5'd0, 1'b0});
`ifdef NAND_BIST_SIGNATURE_EN
        chk("after_abort_sig", sig, s_good);
`endif
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
